// File: rtl/seg7_digit_sequencer_if.sv
// Control pins and decoder-side outputs of the 7-segment digit sequencer.
//   master: drives ena/run/dir/step/clear/cfg_load/cfg_compare, observes outputs
//   slave : the sequencer; drives digit/dp/tick/wrap/state
interface seg7_digit_sequencer_if;
   logic       ena;
   logic       run;
   logic       dir;
   logic       step;
   logic       clear;
   logic       cfg_load;
   logic [7:0] cfg_compare;
   logic [7:0] digit;
   logic       dp;
   logic       tick;
   logic       wrap;
   logic [1:0] state;

   modport master (
      output ena, run, dir, step, clear, cfg_load, cfg_compare,
      input  digit, dp, tick, wrap, state
   );

   modport slave (
      input  ena, run, dir, step, clear, cfg_load, cfg_compare,
      output digit, dp, tick, wrap, state
   );
endinterface

// File: rtl/seg7_digit_sequencer.sv
// Steps the digit fed to the 7-segment decoder through 0..LAST_DIGIT, up or
// down, at a programmable rate, with run/pause/single-step/clear pin control.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus.ena    : global enable, 0 freezes everything but the pin synchronisers
//   bus.run/step/clear : asynchronous pins (2-FF synchronised)
//   bus.dir    : 0 up, 1 down, sampled at each advance
//   bus.cfg_load/cfg_compare : load rate register, period (cfg+1)<<PRESCALE_SHIFT
//   bus.digit/dp/tick/wrap/state : registered outputs
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_STOP  | idle, prescaler held 0, step edge advances one digit
// ST_RUN   | free-running, advance each time prescaler reaches compare
// ST_PAUSE | prescaler frozen, step edge advances one digit
module seg7_digit_sequencer #(
   parameter int LAST_DIGIT     = 9,
   parameter int PRESCALE_SHIFT = 16,
   parameter int RESET_CFG      = 152
) (
   input logic                   clk,
   input logic                   rst_n,
   seg7_digit_sequencer_if.slave bus
);

   localparam int CW = 8 + PRESCALE_SHIFT;
   localparam logic [CW-1:0] RESET_CMP =
      ((CW'(RESET_CFG) + CW'(1)) << PRESCALE_SHIFT) - CW'(1);
   localparam logic [7:0] LAST = 8'(LAST_DIGIT);

   typedef enum logic [1:0] {
      ST_STOP  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   presc_q;
   logic [CW-1:0]   cmp_q;
   logic [7:0]      digit_q;
   logic            dp_q;
   logic            tick_q;
   logic            wrap_q;

   logic            run_s1, run_s2;
   logic            step_s1, step_s2, step_prev;
   logic            clear_s1, clear_s2;

   logic [CW-1:0]   new_cmp;
   logic            step_edge;
   logic [7:0]      nxt_digit;
   logic            nxt_wrap;

   assign new_cmp   = ((CW'(bus.cfg_compare) + CW'(1)) << PRESCALE_SHIFT) - CW'(1);
   assign step_edge = step_s2 & ~step_prev;

   always_comb begin
      nxt_wrap  = 1'b0;
      nxt_digit = digit_q;
      if (bus.dir) begin
         if (digit_q == 8'd0) begin
            nxt_digit = LAST;
            nxt_wrap  = 1'b1;
         end else begin
            nxt_digit = digit_q - 8'd1;
         end
      end else begin
         if (digit_q == LAST) begin
            nxt_digit = 8'd0;
            nxt_wrap  = 1'b1;
         end else begin
            nxt_digit = digit_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_s1    <= 1'b0;
         run_s2    <= 1'b0;
         step_s1   <= 1'b0;
         step_s2   <= 1'b0;
         step_prev <= 1'b0;
         clear_s1  <= 1'b0;
         clear_s2  <= 1'b0;
         state_q   <= ST_STOP;
         presc_q   <= '0;
         cmp_q     <= RESET_CMP;
         digit_q   <= 8'd0;
         dp_q      <= 1'b0;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         // synchronisers keep running with ena=0, so a step edge then is lost
         run_s1    <= bus.run;
         run_s2    <= run_s1;
         step_s1   <= bus.step;
         step_s2   <= step_s1;
         step_prev <= step_s2;
         clear_s1  <= bus.clear;
         clear_s2  <= clear_s1;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
         if (bus.ena) begin
            if (bus.cfg_load)
               cmp_q <= new_cmp;
            if (clear_s2) begin
               state_q <= ST_STOP;
               presc_q <= '0;
               digit_q <= 8'd0;
            end else begin
               case (state_q)
                  ST_STOP: begin
                     presc_q <= '0;
                     if (run_s2)
                        state_q <= ST_RUN;
                     if (step_edge) begin
                        digit_q <= nxt_digit;
                        tick_q  <= 1'b1;
                        wrap_q  <= nxt_wrap;
                        dp_q    <= dp_q ^ nxt_wrap;
                     end
                  end
                  ST_RUN: begin
                     state_q <= run_s2 ? ST_RUN : ST_PAUSE;
                     // a timed advance wins over a coincident reload: both clear the prescaler
                     if (run_s2 && presc_q == cmp_q) begin
                        presc_q <= '0;
                        digit_q <= nxt_digit;
                        tick_q  <= 1'b1;
                        wrap_q  <= nxt_wrap;
                        dp_q    <= dp_q ^ nxt_wrap;
                     end else if (bus.cfg_load && presc_q >= new_cmp) begin
                        presc_q <= '0;
                     end else if (run_s2) begin
                        presc_q <= presc_q + CW'(1);
                     end
                  end
                  ST_PAUSE: begin
                     if (run_s2)
                        state_q <= ST_RUN;
                     if (bus.cfg_load && presc_q >= new_cmp)
                        presc_q <= '0;
                     if (step_edge) begin
                        digit_q <= nxt_digit;
                        tick_q  <= 1'b1;
                        wrap_q  <= nxt_wrap;
                        dp_q    <= dp_q ^ nxt_wrap;
                     end
                  end
                  default: begin
                     state_q <= ST_STOP;
                     presc_q <= '0;
                  end
               endcase
            end
         end
      end
   end

   assign bus.digit = digit_q;
   assign bus.dp    = dp_q;
   assign bus.tick  = tick_q;
   assign bus.wrap  = wrap_q;
   assign bus.state = state_q;

endmodule

// File: tb/tb_seg7_digit_sequencer.sv
module tb_seg7_digit_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   int   vec  = 0;
   int   errs = 0;

   logic [7:0] exp_digit = 8'd0;
   logic       exp_dp    = 1'b0;
   logic       exp_wrap;
   logic       exp_tick;

   seg7_digit_sequencer_if bus();

   seg7_digit_sequencer #(
      .LAST_DIGIT(9), .PRESCALE_SHIFT(0), .RESET_CFG(152)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // reference advance: updates expected digit/dp and sets exp_wrap
   task automatic model_advance();
      exp_wrap = bus.dir ? (exp_digit == 8'd0) : (exp_digit == 8'd9);
      if (bus.dir) exp_digit = (exp_digit == 8'd0) ? 8'd9 : exp_digit - 8'd1;
      else         exp_digit = (exp_digit == 8'd9) ? 8'd0 : exp_digit + 8'd1;
      exp_dp = exp_dp ^ exp_wrap;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) cyc();
      vec++;
      if ({bus.digit, bus.state, bus.dp, bus.tick, bus.wrap} !== 13'd0) begin
         errs++;
         $display("FAIL reset_values: got digit=%0d state=%0d dp=%0b tick=%0b wrap=%0b expected all 0",
                  bus.digit, bus.state, bus.dp, bus.tick, bus.wrap);
      end
      rst_n = 1'b1;
      for (int n = 0; n < 100; n++) begin
         cyc();
         vec++;
         if (bus.tick !== 1'b0 || bus.digit !== 8'd0 || bus.state !== 2'b00 || bus.dp !== 1'b0) begin
            errs++;
            $display("FAIL idle_stop cyc %0d: got tick=%0b digit=%0d state=%0d dp=%0b expected 0,0,0,0",
                     n, bus.tick, bus.digit, bus.state, bus.dp);
         end
      end
   endtask

   task automatic test_run();
      bus.cfg_compare = 8'd3;
      bus.cfg_load    = 1'b1;
      cyc();
      bus.cfg_load = 1'b0;
      bus.run      = 1'b1;
      for (int n = 1; n <= 3; n++) begin
         cyc();
         vec++;
         if (bus.state !== ((n == 3) ? 2'b01 : 2'b00)) begin
            errs++;
            $display("FAIL run_latency cyc %0d: got state=%0d expected %0d", n, bus.state, (n == 3) ? 1 : 0);
         end
      end
      for (int n = 1; n <= 40; n++) begin
         cyc();
         exp_tick = (n % 4 == 0);
         exp_wrap = 1'b0;
         if (exp_tick) model_advance();
         vec++;
         if ({bus.tick, bus.wrap, bus.dp, bus.digit} !== {exp_tick, exp_wrap, exp_dp, exp_digit}) begin
            errs++;
            $display("FAIL run_seq n=%0d: got tick=%0b wrap=%0b dp=%0b digit=%0d expected %0b %0b %0b %0d",
                     n, bus.tick, bus.wrap, bus.dp, bus.digit, exp_tick, exp_wrap, exp_dp, exp_digit);
         end
      end
      vec++;
      if (bus.digit !== 8'd0 || bus.dp !== 1'b1 || bus.wrap !== 1'b1) begin
         errs++;
         $display("FAIL tenth_tick_wrap: got digit=%0d dp=%0b wrap=%0b expected 0 1 1", bus.digit, bus.dp, bus.wrap);
      end
   endtask

   task automatic test_down();
      bus.dir = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         bus.step = (n <= 2);   // step edges are ignored while running
         cyc();
         exp_tick = (n % 4 == 0);
         exp_wrap = 1'b0;
         if (exp_tick) model_advance();
         vec++;
         if ({bus.tick, bus.wrap, bus.dp, bus.digit} !== {exp_tick, exp_wrap, exp_dp, exp_digit}) begin
            errs++;
            $display("FAIL down_seq n=%0d: got tick=%0b wrap=%0b dp=%0b digit=%0d expected %0b %0b %0b %0d",
                     n, bus.tick, bus.wrap, bus.dp, bus.digit, exp_tick, exp_wrap, exp_dp, exp_digit);
         end
         if (n == 4) begin
            vec++;
            if (bus.digit !== 8'd9 || bus.wrap !== 1'b1 || bus.dp !== 1'b0) begin
               errs++;
               $display("FAIL down_wrap: got digit=%0d wrap=%0b dp=%0b expected 9 1 0", bus.digit, bus.wrap, bus.dp);
            end
         end
      end
      bus.dir = 1'b0;
   endtask

   task automatic test_pause_step();
      // prescaler is 0 right after a tick; run drop lands as it reaches 2
      bus.run = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         cyc();
         vec++;
         if (bus.state !== ((n >= 3) ? 2'b10 : 2'b01) || bus.tick !== 1'b0 || bus.digit !== exp_digit) begin
            errs++;
            $display("FAIL pause_entry n=%0d: got state=%0d tick=%0b digit=%0d expected %0d 0 %0d",
                     n, bus.state, bus.tick, bus.digit, (n >= 3) ? 2 : 1, exp_digit);
         end
      end
      bus.step = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         if (n == 3) bus.step = 1'b0;
         cyc();
         exp_tick = (n == 3);
         exp_wrap = 1'b0;
         if (exp_tick) model_advance();
         vec++;
         if ({bus.tick, bus.digit, bus.state} !== {exp_tick, exp_digit, 2'b10}) begin
            errs++;
            $display("FAIL pause_step n=%0d: got tick=%0b digit=%0d state=%0d expected %0b %0d 2",
                     n, bus.tick, bus.digit, bus.state, exp_tick, exp_digit);
         end
      end
      bus.run = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         cyc();
         exp_tick = (n == 5);
         exp_wrap = 1'b0;
         if (exp_tick) model_advance();
         vec++;
         if ({bus.tick, bus.wrap, bus.dp, bus.digit} !== {exp_tick, exp_wrap, exp_dp, exp_digit}) begin
            errs++;
            $display("FAIL resume_tick n=%0d: got tick=%0b wrap=%0b dp=%0b digit=%0d expected %0b %0b %0b %0d",
                     n, bus.tick, bus.wrap, bus.dp, bus.digit, exp_tick, exp_wrap, exp_dp, exp_digit);
         end
      end
   endtask

   task automatic test_clear_step();
      for (int n = 1; n <= 4; n++) begin
         cyc();
         exp_tick = (n == 4);
         if (exp_tick) model_advance();
      end
      vec++;
      if (bus.digit !== exp_digit || bus.tick !== 1'b1) begin
         errs++;
         $display("FAIL pre_clear: got digit=%0d tick=%0b expected %0d 1", bus.digit, bus.tick, exp_digit);
      end
      bus.clear = 1'b1;
      bus.step  = 1'b1;
      bus.run   = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         cyc();
         if (n >= 3) exp_digit = 8'd0;
         vec++;
         if (bus.tick !== 1'b0 || bus.digit !== exp_digit || bus.dp !== exp_dp ||
             bus.state !== ((n >= 3) ? 2'b00 : 2'b01)) begin
            errs++;
            $display("FAIL clear_step n=%0d: got tick=%0b digit=%0d dp=%0b state=%0d expected 0 %0d %0b %0d",
                     n, bus.tick, bus.digit, bus.dp, bus.state, exp_digit, exp_dp, (n >= 3) ? 0 : 1);
         end
      end
      bus.clear = 1'b0;
      bus.step  = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         cyc();
         vec++;
         if (bus.tick !== 1'b0 || bus.digit !== 8'd0 || bus.state !== 2'b00) begin
            errs++;
            $display("FAIL clear_release n=%0d: got tick=%0b digit=%0d state=%0d expected 0 0 0",
                     n, bus.tick, bus.digit, bus.state);
         end
      end
   endtask

   task automatic test_cfg_reload();
      bus.cfg_compare = 8'd7;
      bus.cfg_load    = 1'b1;
      cyc();
      bus.cfg_load = 1'b0;
      bus.run      = 1'b1;
      repeat (3) cyc();
      vec++;
      if (bus.state !== 2'b01) begin
         errs++;
         $display("FAIL reload_run_entry: got state=%0d expected 1", bus.state);
      end
      // n counts edges after RUN entry; reload to cfg 1 at prescaler 3 (n=4),
      // reload to cfg 3 coincident with the timed advance at n=8
      for (int n = 1; n <= 12; n++) begin
         bus.cfg_load    = (n == 4) || (n == 8);
         bus.cfg_compare = (n == 4) ? 8'd1 : 8'd3;
         cyc();
         exp_tick = (n == 6) || (n == 8) || (n == 12);
         exp_wrap = 1'b0;
         if (exp_tick) model_advance();
         vec++;
         if ({bus.tick, bus.digit} !== {exp_tick, exp_digit}) begin
            errs++;
            $display("FAIL cfg_reload n=%0d: got tick=%0b digit=%0d expected %0b %0d",
                     n, bus.tick, bus.digit, exp_tick, exp_digit);
         end
      end
      bus.cfg_load = 1'b0;
   endtask

   task automatic test_ena();
      repeat (2) cyc();   // prescaler now 2 of 3
      bus.ena = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         bus.cfg_load    = (n == 5);
         bus.cfg_compare = 8'd0;
         cyc();
         vec++;
         if (bus.tick !== 1'b0 || bus.wrap !== 1'b0 || bus.digit !== exp_digit || bus.state !== 2'b01) begin
            errs++;
            $display("FAIL ena_freeze n=%0d: got tick=%0b wrap=%0b digit=%0d state=%0d expected 0 0 %0d 1",
                     n, bus.tick, bus.wrap, bus.digit, bus.state, exp_digit);
         end
      end
      bus.cfg_load = 1'b0;
      bus.ena      = 1'b1;
      for (int n = 1; n <= 3; n++) begin
         cyc();
         exp_tick = (n == 2);
         if (exp_tick) model_advance();
         vec++;
         if ({bus.tick, bus.digit} !== {exp_tick, exp_digit}) begin
            errs++;
            $display("FAIL ena_resume n=%0d: got tick=%0b digit=%0d expected %0b %0d",
                     n, bus.tick, bus.digit, exp_tick, exp_digit);
         end
      end
   endtask

   task automatic test_async_reset();
      #3;
      rst_n = 1'b0;
      #1;
      exp_digit = 8'd0;
      exp_dp    = 1'b0;
      vec++;
      if ({bus.digit, bus.state, bus.dp, bus.tick} !== 12'd0) begin
         errs++;
         $display("FAIL async_reset: got digit=%0d state=%0d dp=%0b tick=%0b expected all 0",
                  bus.digit, bus.state, bus.dp, bus.tick);
      end
      #1;
      rst_n = 1'b1;
      repeat (3) cyc();
      vec++;
      if (bus.state !== 2'b01) begin
         errs++;
         $display("FAIL post_reset_run: got state=%0d expected 1", bus.state);
      end
      // reset compare of 152 gives a 153-cycle period
      for (int n = 1; n <= 160; n++) begin
         cyc();
         exp_tick = (n == 153);
         if (exp_tick) model_advance();
         vec++;
         if ({bus.tick, bus.digit} !== {exp_tick, exp_digit}) begin
            errs++;
            $display("FAIL reset_rate n=%0d: got tick=%0b digit=%0d expected %0b %0d",
                     n, bus.tick, bus.digit, exp_tick, exp_digit);
         end
      end
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.ena         = 1'b1;
      bus.run         = 1'b0;
      bus.dir         = 1'b0;
      bus.step        = 1'b0;
      bus.clear       = 1'b0;
      bus.cfg_load    = 1'b0;
      bus.cfg_compare = 8'd0;
      test_reset();
      test_run();
      test_down();
      test_pause_step();
      test_clear_step();
      test_cfg_reload();
      test_ena();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
